// File: rtl/register_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// register_access_ctrl_pkg
// Shared definitions for the host register access controller: default
// parameter values, the wait-counter width and the FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package register_access_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH  = 7;
  localparam int DEF_NUM_REGS    = 8;
  localparam int DEF_BASE_ADDR   = 0;
  localparam int DEF_WAIT_CYCLES = 1;

  // Holds WAIT_CYCLES in the range 0..15.
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/CompareConst.sv
// -----------------------------------------------------------------------------
// CompareConst
// Equality compare of a bus against an elaboration-time constant.
//   i_value : value under test (WIDTH bits)
//   o_match : 1 when i_value == VALUE
// -----------------------------------------------------------------------------
module CompareConst #(
  parameter int WIDTH = 7,
  parameter int VALUE = 0
) (
  input  logic [WIDTH-1:0] i_value,
  output logic             o_match
);

  localparam logic [WIDTH-1:0] K_VALUE = WIDTH'(VALUE);

  assign o_match = (i_value == K_VALUE);

endmodule

// File: rtl/bus_sync.sv
// -----------------------------------------------------------------------------
// bus_sync
// Two-flop synchronizer for one active-low asynchronous host control line.
// Both flops reset to 1 so the synchronized line reads "inactive" after reset.
//   i_clk    : system clock
//   i_reset  : synchronous active-high reset
//   i_async  : asynchronous input
//   o_sync   : synchronized copy (two clk cycles of latency)
// -----------------------------------------------------------------------------
module bus_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/register_access_ctrl.sv
// -----------------------------------------------------------------------------
// register_access_ctrl
// Bridges an asynchronous active-low host bus (CS/RD/WR + address) onto
// single-cycle register read/write strobes in the clk domain.
//
// Host handshake: an access starts when synchronized CS is low and at least
// one of RD/WR is low. The host keeps the address stable and the strobe low
// until it sees its data (reads) or is done (writes); the controller issues
// exactly one regRead/regWrite per access and then waits in RELEASE until CS
// or both strobes go high before accepting a new access. Dropping CS or both
// strobes before the strobe is issued cancels the access silently.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   nHostCS/RD/WR   : asynchronous active-low host controls
//   hostAddr        : host address (ADDR_WIDTH)
//   regSel          : one-hot register select, held WAIT..RELEASE
//   regRead/Write   : one-cycle access strobes
//   dataOutEnable   : host data bus drive enable, reads only, ACCESS..RELEASE
//   busy            : state is not IDLE
//   accessError     : one-cycle pulse on address miss or RD+WR conflict
//   o_dbg_state     : current FSM state
// -----------------------------------------------------------------------------
module register_access_ctrl
  import register_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  nHostCS,
  input  logic                  nHostRD,
  input  logic                  nHostWR,
  input  logic [ADDR_WIDTH-1:0] hostAddr,
  output logic [NUM_REGS-1:0]   regSel,
  output logic                  regRead,
  output logic                  regWrite,
  output logic                  dataOutEnable,
  output logic                  busy,
  output logic                  accessError,
  output logic [2:0]            o_dbg_state
);

  // Synchronized host controls (active low).
  logic w_cs_n;
  logic w_rd_n;
  logic w_wr_n;

  bus_sync u_sync_cs (.i_clk(clk), .i_reset(reset), .i_async(nHostCS), .o_sync(w_cs_n));
  bus_sync u_sync_rd (.i_clk(clk), .i_reset(reset), .i_async(nHostRD), .o_sync(w_rd_n));
  bus_sync u_sync_wr (.i_clk(clk), .i_reset(reset), .i_async(nHostWR), .o_sync(w_wr_n));

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [NUM_REGS-1:0]   r_sel;
  logic                  r_is_rd;
  logic                  r_is_wr;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;

  logic [NUM_REGS-1:0]   w_match;
  logic                  w_start;
  logic                  w_conflict;
  logic                  w_latch_err;
  logic                  w_host_done;

  // Address is captured on entry to LATCH and compared from the register, so
  // later host address changes cannot disturb the decoded select.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_match
    CompareConst #(
      .WIDTH (ADDR_WIDTH),
      .VALUE (BASE_ADDR + gi)
    ) u_cmp (
      .i_value (r_addr),
      .o_match (w_match[gi])
    );
  end

  assign w_start     = !w_cs_n && (!w_rd_n || !w_wr_n);
  assign w_conflict  = !w_rd_n && !w_wr_n;
  assign w_latch_err = (w_match == '0) || w_conflict;
  assign w_host_done = w_cs_n || (w_rd_n && w_wr_n);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Access context: address, select, operation type and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_sel      <= '0;
      r_is_rd    <= 1'b0;
      r_is_wr    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && w_start) begin
        r_addr <= hostAddr;
      end
      if (r_state == ST_LATCH) begin
        // A rejected access keeps select and op clear so RELEASE drives nothing.
        r_sel      <= w_latch_err ? '0 : w_match;
        r_is_rd    <= !w_latch_err && !w_rd_n;
        r_is_wr    <= !w_latch_err && !w_wr_n;
        r_wait_cnt <= WAIT_CNT_W'(WAIT_CYCLES);
      end
      if (r_state == ST_WAIT && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_LATCH;
      end
      ST_LATCH: begin
        w_next = w_latch_err ? ST_RELEASE : ST_WAIT;
      end
      ST_WAIT: begin
        if (w_host_done)             w_next = ST_IDLE;
        else if (r_wait_cnt == '0)   w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (w_host_done) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    regSel        = '0;
    regRead       = 1'b0;
    regWrite      = 1'b0;
    dataOutEnable = 1'b0;
    busy          = (r_state != ST_IDLE);
    accessError   = (r_state == ST_LATCH) && w_latch_err;
    if (r_state == ST_WAIT || r_state == ST_ACCESS || r_state == ST_RELEASE) begin
      regSel = r_sel;
    end
    if (r_state == ST_ACCESS) begin
      regRead  = r_is_rd;
      regWrite = r_is_wr;
    end
    if (r_state == ST_ACCESS || r_state == ST_RELEASE) begin
      dataOutEnable = r_is_rd;
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_register_access_ctrl.sv
module tb_register_access_ctrl;
  import register_access_ctrl_pkg::*;

  localparam int AW   = 7;
  localparam int NR   = 8;
  localparam int BASE = 5;
  localparam int ND   = 3;

  typedef struct {
    int err;
    int rd;
    int wr;
    int busy;
    int sel_cnt;
    int doe;
    int rel;
    int sel;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic nHostCS, nHostRD, nHostWR;
  logic [AW-1:0] hostAddr;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs (WAIT_CYCLES 1, 0, 5) ----------------
  logic [NR-1:0] sel_o [ND];
  logic rd_o [ND], wr_o [ND], doe_o [ND], busy_o [ND], err_o [ND];
  logic [2:0] dbg_o [ND];

  function automatic int wait_of(input int j);
    return (j == 0) ? 1 : ((j == 1) ? 0 : 5);
  endfunction

  register_access_ctrl #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset(reset), .nHostCS(nHostCS), .nHostRD(nHostRD), .nHostWR(nHostWR),
    .hostAddr(hostAddr), .regSel(sel_o[0]), .regRead(rd_o[0]), .regWrite(wr_o[0]),
    .dataOutEnable(doe_o[0]), .busy(busy_o[0]), .accessError(err_o[0]), .o_dbg_state(dbg_o[0]));

  register_access_ctrl #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .nHostCS(nHostCS), .nHostRD(nHostRD), .nHostWR(nHostWR),
    .hostAddr(hostAddr), .regSel(sel_o[1]), .regRead(rd_o[1]), .regWrite(wr_o[1]),
    .dataOutEnable(doe_o[1]), .busy(busy_o[1]), .accessError(err_o[1]), .o_dbg_state(dbg_o[1]));

  register_access_ctrl #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_CYCLES(5)) u_dut_w5 (
    .clk(clk), .reset(reset), .nHostCS(nHostCS), .nHostRD(nHostRD), .nHostWR(nHostWR),
    .hostAddr(hostAddr), .regSel(sel_o[2]), .regRead(rd_o[2]), .regWrite(wr_o[2]),
    .dataOutEnable(doe_o[2]), .busy(busy_o[2]), .accessError(err_o[2]), .o_dbg_state(dbg_o[2]));

  // ---------------- monitor (free-running event counters) ----------------
  int m_err [ND]  = '{default: 0};
  int m_rd [ND]   = '{default: 0};
  int m_wr [ND]   = '{default: 0};
  int m_busy [ND] = '{default: 0};
  int m_sel [ND]  = '{default: 0};
  int m_doe [ND]  = '{default: 0};
  int m_cyc [ND]  = '{default: 0};
  int m_last_sel [ND] = '{default: 0};

  always @(negedge clk) begin
    for (int j = 0; j < ND; j++) begin
      if (err_o[j])        m_err[j]  += 1;
      if (rd_o[j])         m_rd[j]   += 1;
      if (wr_o[j])         m_wr[j]   += 1;
      if (busy_o[j])       m_busy[j] += 1;
      if (sel_o[j] != '0)  m_sel[j]  += 1;
      if (doe_o[j])        m_doe[j]  += 1;
      if (rd_o[j] || wr_o[j]) begin
        m_cyc[j]      = cyc;
        m_last_sel[j] = int'(sel_o[j]);
      end
    end
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Outcome of one host access whose strobes go low at a negedge (cycle 0)
  // and are all released h cycles later. The synced strobe falls 2 cycles
  // after the drive, the access strobe follows WAIT+3 cycles after that, and
  // the controller goes idle 3 cycles after the host release is driven (but
  // never before RELEASE has been entered).
  task automatic model(input int w, input int addr, input bit rd, input bit wr,
                       input int h, output exp_t e);
    bit hit, bad, done;
    int t_idle;
    hit  = (addr >= BASE) && (addr < BASE + NR);
    bad  = !hit || (rd && wr);
    done = !bad && (h >= w + 3);
    t_idle = done ? ((h + 3 > w + 7) ? h + 3 : w + 7) : h + 3;
    e.err     = bad ? 1 : 0;
    e.rd      = (done && rd) ? 1 : 0;
    e.wr      = (done && wr) ? 1 : 0;
    e.busy    = t_idle - 3;
    e.sel_cnt = bad ? 0 : t_idle - 4;
    e.doe     = (done && rd) ? t_idle - (w + 5) : 0;
    e.rel     = w + 5;
    e.sel     = hit ? (1 << (addr - BASE)) : 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_access(input int addr, input bit rd, input bit wr, input int h,
                           input string tag);
    int b_err [ND], b_rd [ND], b_wr [ND], b_busy [ND], b_sel [ND], b_doe [ND];
    int t0;
    exp_t e;
    @(negedge clk);
    b_err = m_err; b_rd = m_rd; b_wr = m_wr;
    b_busy = m_busy; b_sel = m_sel; b_doe = m_doe;
    t0 = cyc;
    hostAddr = AW'(addr);
    nHostCS  = 1'b0;
    nHostRD  = !rd;
    nHostWR  = !wr;
    for (int i = 1; i <= h; i++) begin
      @(negedge clk);
      // Scramble the address once it has been captured.
      if (i == 3) hostAddr = AW'($urandom_range(0, (1 << AW) - 1));
    end
    nHostCS = 1'b1;
    nHostRD = 1'b1;
    nHostWR = 1'b1;
    repeat (5) @(negedge clk);
    for (int j = 0; j < ND; j++) begin
      model(wait_of(j), addr, rd, wr, h, e);
      check_eq($sformatf("%s_w%0d_err", tag, wait_of(j)), m_err[j] - b_err[j], e.err);
      check_eq($sformatf("%s_w%0d_rd", tag, wait_of(j)), m_rd[j] - b_rd[j], e.rd);
      check_eq($sformatf("%s_w%0d_wr", tag, wait_of(j)), m_wr[j] - b_wr[j], e.wr);
      check_eq($sformatf("%s_w%0d_busy", tag, wait_of(j)), m_busy[j] - b_busy[j], e.busy);
      check_eq($sformatf("%s_w%0d_selcnt", tag, wait_of(j)), m_sel[j] - b_sel[j], e.sel_cnt);
      check_eq($sformatf("%s_w%0d_doe", tag, wait_of(j)), m_doe[j] - b_doe[j], e.doe);
      if (e.rd + e.wr > 0) begin
        check_eq($sformatf("%s_w%0d_latency", tag, wait_of(j)), m_cyc[j] - t0, e.rel);
        check_eq($sformatf("%s_w%0d_sel", tag, wait_of(j)), m_last_sel[j], e.sel);
      end
      check_eq($sformatf("%s_w%0d_idle", tag, wait_of(j)), int'(busy_o[j]), 0);
    end
  endtask

  task automatic reset_in_wait();
    int b_err [ND], b_rd [ND], b_wr [ND];
    @(negedge clk);
    b_err = m_err; b_rd = m_rd; b_wr = m_wr;
    hostAddr = AW'(BASE + 3);
    nHostCS  = 1'b0;
    nHostWR  = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 0; j < ND; j++)
      check_eq($sformatf("pre_rst_w%0d_state", wait_of(j)), int'(dbg_o[j]), int'(ST_WAIT));
    reset   = 1'b1;
    nHostCS = 1'b1;
    nHostWR = 1'b1;
    @(negedge clk);
    for (int j = 0; j < ND; j++) begin
      check_eq($sformatf("rst_w%0d_outputs", wait_of(j)),
               int'({sel_o[j], rd_o[j], wr_o[j], doe_o[j], busy_o[j], err_o[j]}), 0);
      check_eq($sformatf("rst_w%0d_state", wait_of(j)), int'(dbg_o[j]), int'(ST_IDLE));
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    for (int j = 0; j < ND; j++) begin
      check_eq($sformatf("rst_w%0d_strobes", wait_of(j)),
               (m_rd[j] - b_rd[j]) + (m_wr[j] - b_wr[j]), 0);
      check_eq($sformatf("rst_w%0d_err", wait_of(j)), m_err[j] - b_err[j], 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    nHostCS  = 1'b1;
    nHostRD  = 1'b1;
    nHostWR  = 1'b1;
    hostAddr = '0;
    repeat (3) @(negedge clk);
    for (int j = 0; j < ND; j++) begin
      check_eq($sformatf("por_w%0d_outputs", wait_of(j)),
               int'({sel_o[j], rd_o[j], wr_o[j], doe_o[j], busy_o[j], err_o[j]}), 0);
      check_eq($sformatf("por_w%0d_state", wait_of(j)), int'(dbg_o[j]), int'(ST_IDLE));
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    do_access(BASE + 3, 1'b0, 1'b1, 10, "wr3");
    do_access(BASE + 0, 1'b1, 1'b0, 8, "rd0");
    do_access(BASE + NR, 1'b1, 1'b0, 6, "miss_hi");
    do_access(BASE - 1, 1'b0, 1'b1, 6, "miss_lo");
    do_access(BASE + 2, 1'b1, 1'b1, 6, "conflict");
    do_access(BASE + 5, 1'b0, 1'b1, 5, "cs_drop");
    do_access(BASE + 1, 1'b1, 1'b0, 3, "short_rd");
    do_access(BASE + NR - 1, 1'b1, 1'b0, 2, "min_hold");
    reset_in_wait();
    do_access(BASE + 3, 1'b0, 1'b1, 10, "post_rst_wr3");

    for (int n = 0; n < 40; n++) begin
      int addr, pick, op, h;
      bit rd, wr;
      pick = $urandom_range(0, 9);
      if (pick < 7)       addr = BASE + $urandom_range(0, NR - 1);
      else if (pick == 7) addr = BASE + NR;
      else if (pick == 8) addr = $urandom_range(0, (1 << AW) - 1);
      else                addr = BASE - 1;
      op = $urandom_range(0, 5);
      wr = (op <= 2) || (op == 5);
      rd = (op >= 3);
      h  = $urandom_range(2, 12);
      do_access(addr, rd, wr, h, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/register_access_ctrl.md
REGISTER_ACCESS_CTRL -- requirements
Module: register_access_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 7: host address width; SHALL be 1..9.
REQ-002 Parameter NUM_REGS, default 8: number of decoded registers; SHALL be 1..16.
REQ-003 Parameter BASE_ADDR, default 0: address of register 0; register i SHALL decode at BASE_ADDR+i, and BASE_ADDR+NUM_REGS-1 SHALL fit in ADDR_WIDTH bits.
REQ-004 Parameter WAIT_CYCLES, default 1: wait states inserted before the access strobe; range 0..15.
REQ-005 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 nHostCS  in  1  host chip select, active low, asynchronous to clk.
REQ-008 nHostRD  in  1  host read strobe, active low, asynchronous.
REQ-009 nHostWR  in  1  host write strobe, active low, asynchronous.
REQ-010 hostAddr  in  ADDR_WIDTH  host address, stable while nHostCS is low.
REQ-011 regSel  out  NUM_REGS  one-hot selected register, held from LATCH exit to RELEASE exit.
REQ-012 regRead  out  1  one-cycle read strobe to the selected register.
REQ-013 regWrite  out  1  one-cycle write strobe to the selected register.
REQ-014 dataOutEnable  out  1  host data bus drive enable for reads.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 accessError  out  1  one-cycle pulse on an address miss or a conflicting strobe.

Function
REQ-017 nHostCS, nHostRD and nHostWR SHALL each pass a 2-flop synchronizer; the FSM SHALL use only the synchronized copies.
REQ-018 An access SHALL start when synced CS is low and at least one of RD or WR is low.
REQ-019 FSM states SHALL be IDLE, LATCH, WAIT, ACCESS and RELEASE.
REQ-020 IDLE SHALL transition to LATCH on an access start.
REQ-021 LATCH SHALL register hostAddr, the operation type (read/write) and the per-register match vector.
REQ-022 LATCH SHALL go to RELEASE with an accessError pulse if the match vector is zero or RD and WR are both low; otherwise it SHALL load waitCounter with WAIT_CYCLES and go to WAIT.
REQ-023 WAIT SHALL decrement waitCounter each cycle and go to ACCESS when the counter is 0; with WAIT_CYCLES=0 it SHALL stay in WAIT exactly 1 cycle.
REQ-024 If synced CS rises, or both strobes are released, during WAIT, the FSM SHALL return to IDLE with no strobe and no error.
REQ-025 ACCESS SHALL last 1 cycle and pulse regWrite for a write or regRead for a read, then go to RELEASE.
REQ-026 dataOutEnable SHALL be high from ACCESS through RELEASE for reads only, and low otherwise.
REQ-027 RELEASE SHALL hold until synced CS is high or both strobes are high, then go to IDLE; a new access SHALL NOT start in the same cycle.
REQ-028 Total latency from the synced strobe edge to the access strobe SHALL be WAIT_CYCLES+3 clk cycles.
REQ-029 Address changes after LATCH SHALL be ignored until the next access.
REQ-030 Exactly one regSel bit SHALL be set when regRead or regWrite is high.

Reset
REQ-031 While reset is high, the state SHALL go to IDLE at the next edge, synchronizer flops SHALL be set to 1 (inactive), waitCounter to 0, and regSel, regRead, regWrite, dataOutEnable, busy and accessError to 0.
REQ-032 Reset asserted mid-access SHALL suppress any pending strobe; after release, the FSM SHALL require a fresh access start (RELEASE semantics are not preserved).

Structure
REQ-033 The state encoding and the default parameter values SHALL live in the shared FPGA package.
REQ-034 The per-register match SHALL use NUM_REGS CompareConst instances (WIDTH=ADDR_WIDTH, VALUE=BASE_ADDR+i).
REQ-035 The synchronizer SHALL be one sub-module, bus_sync, instantiated 3 times.

Verification
REQ-036 Write to BASE_ADDR+3, WAIT_CYCLES=1: regSel=0x08, and regWrite is high for exactly 1 cycle, 4 cycles after the synced nHostWR falls.
REQ-037 Read from BASE_ADDR+0, WAIT_CYCLES=0: regRead pulses at cycle 3, and dataOutEnable stays high until nHostCS rises plus 2 cycles.
REQ-038 Access to address BASE_ADDR+NUM_REGS: accessError is pulsed once, with no regRead, no regWrite and regSel=0.
REQ-039 nHostRD and nHostWR low together: accessError is pulsed and no strobe is issued.
REQ-040 nHostCS released during WAIT (WAIT_CYCLES=5): the FSM returns to IDLE with no strobe and no error.
REQ-041 Reset asserted in WAIT: all outputs are 0 after 1 cycle, and the next complete access behaves as in REQ-036.
